// File: rtl/tiny_evr_decoder_if.sv
// Event-link receive interface: the aligned word stream coming in and the
// decoded timing outputs going out to the timestamping logic.
interface tiny_evr_decoder_if #(
    parameter int SECONDS_WIDTH = 32
);
    logic [15:0]              evrRxWord;
    logic [1:0]               evrRxIsK;
    logic                     evrRxValid;

    logic [7:0]               distributedBus;
    logic [7:0]               eventCode;
    logic                     eventStrobe;
    logic                     heartbeatStrobe;
    logic                     secondsMarkerStrobe;
    logic [SECONDS_WIDTH-1:0] seconds;
    logic                     secondsValid;
    logic [31:0]              ticks;
    logic                     heartbeatLost;

    // Link/transceiver side drives the words and consumes the decoded outputs.
    modport master (
        output evrRxWord, evrRxIsK, evrRxValid,
        input  distributedBus, eventCode, eventStrobe, heartbeatStrobe,
        input  secondsMarkerStrobe, seconds, secondsValid, ticks, heartbeatLost
    );

    // Decoder side.
    modport slave (
        input  evrRxWord, evrRxIsK, evrRxValid,
        output distributedBus, eventCode, eventStrobe, heartbeatStrobe,
        output secondsMarkerStrobe, seconds, secondsValid, ticks, heartbeatLost
    );
endinterface

// File: rtl/tiny_evr_decoder.sv
// Receive-side event decoder. Two-stage pipeline: stage 1 captures the raw
// link word, stage 2 decodes it and updates every output on the same edge,
// so all outputs share a 2-cycle latency from the input word.
module tiny_evr_decoder #(
    parameter int SECONDS_WIDTH     = 32,
    parameter int HEARTBEAT_TIMEOUT = 250000000
) (
    input  logic             evrRxClk,
    input  logic             evrRxReset,
    tiny_evr_decoder_if.slave link
);

    // shiftCount must reach SECONDS_WIDTH+1 to flag an overlong sequence.
    localparam int                SC_W       = $clog2(SECONDS_WIDTH + 2);
    localparam logic [SC_W-1:0]   SC_FULL    = SC_W'(SECONDS_WIDTH);
    localparam logic [SC_W-1:0]   SC_OVER    = SC_W'(SECONDS_WIDTH + 1);
    localparam logic [SC_W-1:0]   SC_ONE     = SC_W'(1);
    localparam int                WD_W       = $clog2(HEARTBEAT_TIMEOUT);
    localparam logic [WD_W-1:0]   WD_RELOAD  = WD_W'(HEARTBEAT_TIMEOUT - 1);
    localparam logic [WD_W-1:0]   WD_ONE     = WD_W'(1);

    logic [15:0]              rxWordQ;
    logic [1:0]               rxIsKQ;
    logic                     rxValidQ;

    logic [SECONDS_WIDTH-1:0] shiftReg;
    logic [SC_W-1:0]          shiftCount;
    logic [WD_W-1:0]          watchdog;

    logic [7:0]               codeByte;
    logic                     lowData;
    logic                     isShift;
    logic                     isHeartbeat;
    logic                     isMarker;
    logic                     isEvent;

    // Stage 1: capture the raw link word.
    always_ff @(posedge evrRxClk or posedge evrRxReset) begin
        if (evrRxReset) begin
            rxWordQ  <= '0;
            rxIsKQ   <= '0;
            rxValidQ <= 1'b0;
        end else begin
            rxWordQ  <= link.evrRxWord;
            rxIsKQ   <= link.evrRxIsK;
            rxValidQ <= link.evrRxValid;
        end
    end

    // Classify the low byte; K characters and invalid words decode as null.
    always_comb begin
        codeByte    = rxWordQ[7:0];
        lowData     = rxValidQ && !rxIsKQ[0];
        isShift     = lowData && (codeByte[7:1] == 7'b0111000);
        isHeartbeat = lowData && (codeByte == 8'h7A);
        isMarker    = lowData && (codeByte == 8'h7D);
        isEvent     = lowData && (codeByte != 8'h00) && !isShift;
    end

    // Distributed bus byte follows every valid data high byte.
    always_ff @(posedge evrRxClk or posedge evrRxReset) begin
        if (evrRxReset) begin
            link.distributedBus <= '0;
        end else if (rxValidQ && !rxIsKQ[1]) begin
            link.distributedBus <= rxWordQ[15:8];
        end
    end

    // Single-cycle strobes; eventCode holds between events.
    always_ff @(posedge evrRxClk or posedge evrRxReset) begin
        if (evrRxReset) begin
            link.eventCode           <= '0;
            link.eventStrobe         <= 1'b0;
            link.heartbeatStrobe     <= 1'b0;
            link.secondsMarkerStrobe <= 1'b0;
        end else begin
            link.eventStrobe         <= isEvent;
            link.heartbeatStrobe     <= isHeartbeat;
            link.secondsMarkerStrobe <= isMarker;
            if (isEvent) begin
                link.eventCode <= codeByte;
            end
        end
    end

    // Seconds reassembly: shift in bits, commit on marker only if the count is exact.
    always_ff @(posedge evrRxClk or posedge evrRxReset) begin
        if (evrRxReset) begin
            shiftReg          <= '0;
            shiftCount        <= '0;
            link.seconds      <= '0;
            link.secondsValid <= 1'b0;
        end else if (!rxValidQ) begin
            shiftCount        <= '0;
            link.secondsValid <= 1'b0;
        end else if (isShift) begin
            shiftReg <= {shiftReg[SECONDS_WIDTH-2:0], codeByte[0]};
            if (shiftCount != SC_OVER) begin
                shiftCount <= shiftCount + SC_ONE;
            end
        end else if (isMarker) begin
            if (shiftCount == SC_FULL) begin
                link.seconds      <= shiftReg;
                link.secondsValid <= 1'b1;
            end else begin
                link.seconds      <= link.seconds + SECONDS_WIDTH'(1);
                link.secondsValid <= 1'b0;
            end
            shiftCount <= '0;
        end
    end

    // Ticks since the last seconds marker, saturating.
    always_ff @(posedge evrRxClk or posedge evrRxReset) begin
        if (evrRxReset) begin
            link.ticks <= '0;
        end else if (isMarker) begin
            link.ticks <= '0;
        end else if (link.ticks != 32'hFFFF_FFFF) begin
            link.ticks <= link.ticks + 32'd1;
        end
    end

    // Heartbeat watchdog: down-counter parked at zero; lost flags once it sits at terminal count.
    always_ff @(posedge evrRxClk or posedge evrRxReset) begin
        if (evrRxReset) begin
            watchdog           <= WD_RELOAD;
            link.heartbeatLost <= 1'b1;
        end else if (isHeartbeat) begin
            watchdog           <= WD_RELOAD;
            link.heartbeatLost <= 1'b0;
        end else if (watchdog == '0) begin
            link.heartbeatLost <= 1'b1;
        end else begin
            watchdog <= watchdog - WD_ONE;
        end
    end

endmodule

// File: tb/tb_tiny_evr_decoder.sv
// Bench for tiny_evr_decoder: directed scenarios plus a randomized word
// stream, each decoded output compared against a behavioural model.
module tb_tiny_evr_decoder;

    localparam int SW      = 32;
    localparam int TIMEOUT = 100;

    localparam logic [15:0] IDLE_W = 16'h00BC;
    localparam logic [1:0]  IDLE_K = 2'b01;

    typedef struct {
        logic [7:0]  bus;
        logic [7:0]  code;
        logic        evStb;
        logic        hbStb;
        logic        mkStb;
        logic [31:0] sec;
        logic        secValid;
        logic [31:0] ticks;
        logic        lost;
    } exp_t;

    logic evrRxClk   = 1'b0;
    logic evrRxReset = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    exp_t expQ[$];

    // Behavioural model state
    logic [7:0]  mBus;
    logic [7:0]  mCode;
    logic [31:0] mSec;
    logic        mSecValid;
    longint      mTicks;
    bit          mBits[$];
    bit          mHbSeen;
    int          mAge;

    tiny_evr_decoder_if #(.SECONDS_WIDTH(SW)) evrIf ();

    tiny_evr_decoder #(
        .SECONDS_WIDTH    (SW),
        .HEARTBEAT_TIMEOUT(TIMEOUT)
    ) dut (
        .evrRxClk  (evrRxClk),
        .evrRxReset(evrRxReset),
        .link      (evrIf)
    );

    always #5 evrRxClk = ~evrRxClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic void modelReset();
        mBus      = '0;
        mCode     = '0;
        mSec      = '0;
        mSecValid = 1'b0;
        mTicks    = 0;
        mBits.delete();
        mHbSeen   = 1'b0;
        mAge      = 0;
    endfunction

    // One decoded word: updates model state and returns the outputs it implies.
    function automatic exp_t modelStep(input logic [15:0] w, input logic [1:0] k, input logic v);
        exp_t        e;
        logic [7:0]  c;
        logic [31:0] acc;
        bit          hb;
        bit          mk;
        bit          ev;
        c  = w[7:0];
        hb = 0;
        mk = 0;
        ev = 0;
        if (v && !k[1]) mBus = w[15:8];
        if (!v) begin
            mBits.delete();
            mSecValid = 1'b0;
        end else if (!k[0]) begin
            if (c == 8'h70 || c == 8'h71) begin
                mBits.push_back(c[0]);
            end else if (c != 8'h00) begin
                ev    = 1;
                mCode = c;
                if (c == 8'h7A) hb = 1;
                if (c == 8'h7D) begin
                    mk = 1;
                    if (mBits.size() == SW) begin
                        acc = 0;
                        foreach (mBits[i]) acc = {acc[30:0], mBits[i]};
                        mSec      = acc;
                        mSecValid = 1'b1;
                    end else begin
                        mSec      = mSec + 1;
                        mSecValid = 1'b0;
                    end
                    mBits.delete();
                end
            end
        end
        if (mk) mTicks = 0;
        else if (mTicks < 64'hFFFF_FFFF) mTicks = mTicks + 1;
        if (hb) begin
            mHbSeen = 1;
            mAge    = 0;
        end else if (mAge < 1000000) begin
            mAge++;
        end
        e.bus      = mBus;
        e.code     = mCode;
        e.evStb    = ev;
        e.hbStb    = hb;
        e.mkStb    = mk;
        e.sec      = mSec;
        e.secValid = mSecValid;
        e.ticks    = mTicks[31:0];
        e.lost     = !mHbSeen || (mAge >= TIMEOUT);
        return e;
    endfunction

    task automatic checkExp(input exp_t e);
        chk("distributedBus", 32'(evrIf.distributedBus), 32'(e.bus));
        chk("eventCode", 32'(evrIf.eventCode), 32'(e.code));
        chk("eventStrobe", 32'(evrIf.eventStrobe), 32'(e.evStb));
        chk("heartbeatStrobe", 32'(evrIf.heartbeatStrobe), 32'(e.hbStb));
        chk("secondsMarkerStrobe", 32'(evrIf.secondsMarkerStrobe), 32'(e.mkStb));
        chk("seconds", evrIf.seconds, e.sec);
        chk("secondsValid", 32'(evrIf.secondsValid), 32'(e.secValid));
        chk("ticks", evrIf.ticks, e.ticks);
        chk("heartbeatLost", 32'(evrIf.heartbeatLost), 32'(e.lost));
    endtask

    task automatic chkResetVals(input string tag);
        chk({tag, ".distributedBus"}, 32'(evrIf.distributedBus), 32'h0);
        chk({tag, ".eventCode"}, 32'(evrIf.eventCode), 32'h0);
        chk({tag, ".eventStrobe"}, 32'(evrIf.eventStrobe), 32'h0);
        chk({tag, ".heartbeatStrobe"}, 32'(evrIf.heartbeatStrobe), 32'h0);
        chk({tag, ".secondsMarkerStrobe"}, 32'(evrIf.secondsMarkerStrobe), 32'h0);
        chk({tag, ".seconds"}, evrIf.seconds, 32'h0);
        chk({tag, ".secondsValid"}, 32'(evrIf.secondsValid), 32'h0);
        chk({tag, ".ticks"}, evrIf.ticks, 32'h0);
        chk({tag, ".heartbeatLost"}, 32'(evrIf.heartbeatLost), 32'h1);
    endtask

    // Drive one word; outputs are then compared against the word driven one step earlier.
    task automatic step(input logic [15:0] w, input logic [1:0] k, input logic v);
        evrIf.evrRxWord  = w;
        evrIf.evrRxIsK   = k;
        evrIf.evrRxValid = v;
        expQ.push_back(modelStep(w, k, v));
        @(negedge evrRxClk);
        if (expQ.size() >= 2) checkExp(expQ.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(IDLE_W, IDLE_K, 1'b1);
    endtask

    task automatic shiftBits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) step({8'h11, 7'b0111000, val[i % 32]}, 2'b00, 1'b1);
    endtask

    task automatic marker();
        step(16'h007D, 2'b00, 1'b1);
    endtask

    // Called at a negedge: asynchronous assert, check without a clock edge, release on a negedge.
    task automatic doReset(input string tag);
        #1 evrRxReset = 1'b1;
        #1 chkResetVals(tag);
        evrIf.evrRxValid = 1'b0;
        @(negedge evrRxClk);
        @(negedge evrRxClk);
        evrRxReset = 1'b0;
        expQ.delete();
        modelReset();
        expQ.push_back(modelStep(16'h0000, 2'b00, 1'b0));
    endtask

    initial begin
        logic [7:0] c;
        logic [1:0] k;
        logic       v;
        int         r;

        evrIf.evrRxWord  = '0;
        evrIf.evrRxIsK   = '0;
        evrIf.evrRxValid = 1'b0;
        @(negedge evrRxClk);
        doReset("reset");

        // Full 32-bit load
        shiftBits(32'h5A5A1234, 32);
        marker();
        idle(1);
        chk("load.seconds", evrIf.seconds, 32'h5A5A1234);
        chk("load.secondsValid", 32'(evrIf.secondsValid), 32'h1);
        chk("load.markerStrobe", 32'(evrIf.secondsMarkerStrobe), 32'h1);
        chk("load.eventCode", 32'(evrIf.eventCode), 32'h7D);
        chk("load.ticks0", evrIf.ticks, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            idle(1);
            chk("load.ticksCount", evrIf.ticks, 32'(i));
        end

        // Short and overlong sequences
        shiftBits(32'h10, 32);
        marker();
        idle(1);
        chk("prior.seconds", evrIf.seconds, 32'h10);
        shiftBits(32'hFFFF0000, 31);
        marker();
        idle(1);
        chk("short.seconds", evrIf.seconds, 32'h11);
        chk("short.secondsValid", 32'(evrIf.secondsValid), 32'h0);
        shiftBits(32'hA5A5A5A5, 33);
        marker();
        idle(1);
        chk("over.seconds", evrIf.seconds, 32'h12);
        chk("over.secondsValid", 32'(evrIf.secondsValid), 32'h0);

        // Event, comma, null
        step(16'h3C05, 2'b00, 1'b1);
        step(16'h3CBC, 2'b01, 1'b1);
        chk("evt.strobe", 32'(evrIf.eventStrobe), 32'h1);
        chk("evt.code", 32'(evrIf.eventCode), 32'h05);
        chk("evt.bus", 32'(evrIf.distributedBus), 32'h3C);
        step(16'h0000, 2'b00, 1'b1);
        chk("comma.strobe", 32'(evrIf.eventStrobe), 32'h0);
        chk("comma.code", 32'(evrIf.eventCode), 32'h05);
        idle(1);
        chk("null.strobe", 32'(evrIf.eventStrobe), 32'h0);
        chk("null.bus", 32'(evrIf.distributedBus), 32'h00);

        // Heartbeat watchdog
        for (int p = 0; p < 4; p++) begin
            step(16'h007A, 2'b00, 1'b1);
            idle(89);
            chk("hb.keptAlive", 32'(evrIf.heartbeatLost), 32'h0);
        end
        step(16'h007A, 2'b00, 1'b1);
        idle(100);
        chk("hb.notYetLost", 32'(evrIf.heartbeatLost), 32'h0);
        idle(1);
        chk("hb.lostAt100", 32'(evrIf.heartbeatLost), 32'h1);
        idle(20);
        step(16'h007A, 2'b00, 1'b1);
        idle(1);
        chk("hb.recoverStrobe", 32'(evrIf.heartbeatStrobe), 32'h1);
        chk("hb.recoverLost", 32'(evrIf.heartbeatLost), 32'h0);

        // Link loss mid-shift
        shiftBits(32'h12345678, 16);
        step(16'h007A, 2'b00, 1'b0);
        idle(1);
        chk("loss.noHbStrobe", 32'(evrIf.heartbeatStrobe), 32'h0);
        chk("loss.noEvStrobe", 32'(evrIf.eventStrobe), 32'h0);
        shiftBits(32'h12345678, 16);
        marker();
        idle(1);
        chk("loss.secondsValid", 32'(evrIf.secondsValid), 32'h0);
        chk("loss.markerStrobe", 32'(evrIf.secondsMarkerStrobe), 32'h1);

        // Randomized stream
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 15);
            if (r <= 5)       c = 8'h70 | 8'($urandom_range(0, 1));
            else if (r == 6)  c = 8'h7A;
            else if (r == 7)  c = 8'h7D;
            else if (r == 8)  c = 8'h00;
            else if (r == 9)  c = 8'hBC;
            else              c = 8'($urandom_range(1, 255));
            k = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            if (c == 8'hBC) k[0] = 1'b1;
            v = ($urandom_range(0, 11) != 0);
            step({8'($urandom_range(0, 255)), c}, k, v);
        end

        // Asynchronous reset mid-shift and mid-strobe
        shiftBits(32'h3FF, 10);
        step(16'h4433, 2'b00, 1'b1);
        idle(1);
        chk("preReset.strobe", 32'(evrIf.eventStrobe), 32'h1);
        doReset("midReset");
        shiftBits(32'h3FFFFF, 22);
        marker();
        idle(1);
        chk("postReset.seconds", evrIf.seconds, 32'h1);
        chk("postReset.secondsValid", 32'(evrIf.secondsValid), 32'h0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
